// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter peripheral: register map,
// CTRL/STATUS bit positions and the transmit FSM encoding.
package uart_tx_dev_pkg;

    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_CTRL = 2'd1;
    localparam logic [1:0] UART_STAT = 2'd2;
    localparam logic [1:0] UART_DIV  = 2'd3;

    localparam int CTRL_TXEN = 0;
    localparam int CTRL_IE   = 1;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Reload value for the bit down-counter; a divisor of 0 acts as 1.
    function automatic logic [15:0] div_reload(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO. Pushes while full and pops while empty are ignored;
// the count is one bit wider than the pointers so full and empty differ.
module uart_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, bit-period down-counter
// and transmit FSM around a byte FIFO.
//
//   state | meaning
//   IDLE  | line high, waiting for TXEN and a queued byte
//   START | start bit (txd low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (txd high); chains straight into START if more is queued
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    ctrl;
    logic [15:0]   div;
    logic          wr_data;
    logic          wr_ctrl;
    logic          wr_div;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [15:0]   bit_cnt;
    logic [15:0]   bit_cnt_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nx;
    logic [7:0]    shift;
    logic [7:0]    shift_nx;
    logic          txd_nx;
    logic          bit_end;
    logic          busy;
    logic          can_start;

    logic          unused_bits;
    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    assign wr_data = WE && (Addr[3:2] == UART_DATA);
    assign wr_ctrl = WE && (Addr[3:2] == UART_CTRL);
    assign wr_div  = WE && (Addr[3:2] == UART_DIV);

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (Din[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy      = (state != IDLE);
    assign bit_end   = (bit_cnt == 16'd0);
    assign can_start = ctrl[CTRL_TXEN] && !fifo_empty;

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        fifo_pop   = 1'b0;
        txd_nx     = 1'b1;
        case (state)
            IDLE: begin
                if (can_start) begin
                    state_nx   = START;
                    fifo_pop   = 1'b1;
                    shift_nx   = fifo_dout;
                    bit_cnt_nx = div_reload(div);
                end
            end
            START: begin
                txd_nx = 1'b0;
                if (bit_end) begin
                    state_nx   = DATA;
                    bit_idx_nx = 3'd0;
                    bit_cnt_nx = div_reload(div);
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                txd_nx = shift[0];
                if (bit_end) begin
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_cnt_nx = div_reload(div);
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                txd_nx = 1'b1;
                if (bit_end) begin
                    // Chain the next frame with no idle bit in between.
                    if (can_start) begin
                        state_nx   = START;
                        fifo_pop   = 1'b1;
                        shift_nx   = fifo_dout;
                        bit_cnt_nx = div_reload(div);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            txd     <= 1'b1;
            IRQ     <= 1'b0;
            ctrl    <= 2'b00;
            div     <= DIV_RESET;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            txd     <= txd_nx;
            IRQ     <= ctrl[CTRL_IE] & fifo_empty & ~busy;
            if (wr_ctrl) begin
                ctrl <= Din[1:0];
            end
            if (wr_div) begin
                div <= Din[15:0];
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            UART_CTRL: Dout[1:0] = ctrl;
            UART_STAT: begin
                Dout[STAT_EMPTY]           = fifo_empty;
                Dout[STAT_FULL]            = fifo_full;
                Dout[STAT_BUSY]            = busy;
                Dout[STAT_COUNT_LSB +: CW] = fifo_count;
            end
            UART_DIV:  Dout[15:0] = div;
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: register vectors from a table, then
// directed frame, FIFO, interrupt, divisor, TXEN and reset sequences.
module tb_uart_tx_dev;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_DIV  = 2'd3;

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [9];

    uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        Addr = {28'd0, a};
        #1;
        check(name, Dout, exp);
    endtask

    task automatic wait_fall(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Checks the rest of a frame once 'done' samples of it have gone by.
    task automatic check_frame(input logic [7:0] b, input int pf, input int pr,
                               input int done);
        int   bad;
        int   idx;
        logic e;
        logic [7:0] bb;
        bb  = b;
        bad = 0;
        for (int j = done; j < pf + 9 * pr; j++) begin
            @(negedge clk);
            idx = (j < pf) ? 0 : 1 + (j - pf) / pr;
            if (idx == 0)      e = 1'b0;
            else if (idx == 9) e = 1'b1;
            else               e = bb[idx-1];
            if (txd !== e || IRQ !== 1'b0) bad++;
        end
        check($sformatf("frame_%02h_bad_samples", b), 32'(bad), 32'd0);
    endtask

    task automatic check_idle(input int n, input string name);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"ctrl_upper_masked", A_CTRL, 1'b1, 32'hFFFF_FFFC, 32'h0};
        vecs[1] = '{"ctrl_ie",           A_CTRL, 1'b1, 32'h0000_0002, 32'h2};
        vecs[2] = '{"ctrl_clear",        A_CTRL, 1'b1, 32'h0000_0000, 32'h0};
        vecs[3] = '{"div_upper_masked",  A_DIV,  1'b1, 32'hABCD_1234, 32'h1234};
        vecs[4] = '{"div_4",             A_DIV,  1'b1, 32'h0000_0004, 32'h4};
        vecs[5] = '{"stat_write_ignored",A_STAT, 1'b1, 32'hFFFF_FFFF, 32'h001};
        vecs[6] = '{"data_reads_zero",   A_DATA, 1'b0, 32'h0,         32'h0};
        vecs[7] = '{"ctrl_both",         A_CTRL, 1'b1, 32'h0000_0003, 32'h3};
        vecs[8] = '{"ctrl_off",          A_CTRL, 1'b1, 32'h0000_0000, 32'h0};

        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(IRQ), 32'd0);
        rd(A_DIV,  32'd868, "rst_div");
        rd(A_STAT, 32'h001, "rst_stat");
        rd(A_CTRL, 32'h0,   "rst_ctrl");

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Single frame with start latency
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'hA5);
        rd(A_STAT, 32'h010, "lat_count1");
        @(negedge clk);
        check("lat_txd_high_n1", 32'(txd), 32'd1);
        rd(A_STAT, 32'h005, "lat_popped_busy");
        @(negedge clk);
        check("lat_txd_fall_n2", 32'(txd), 32'd0);
        check_frame(8'hA5, 4, 4, 1);
        rd(A_STAT, 32'h001, "single_done");

        // FIFO full, then back-to-back drain
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'(i));
        rd(A_STAT, 32'h082, "fifo_full_count8");
        wr(A_CTRL, 32'h1);
        wait_fall(10, "drain_start");
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check($sformatf("b2b_no_gap_%0d", k), 32'(txd), 32'd0);
            end
            check_frame(8'(k), 4, 4, 1);
        end
        rd(A_STAT, 32'h001, "drain_done");
        check_idle(30, "dropped_byte_not_sent");

        // Interrupt
        wr(A_DIV, 32'h2);
        wr(A_CTRL, 32'h3);
        @(negedge clk);
        check("irq_idle_empty", 32'(IRQ), 32'd1);
        wr(A_DATA, 32'h96);
        @(negedge clk);
        check("irq_low_busy", 32'(IRQ), 32'd0);
        wait_fall(5, "irq_frame_start");
        check_frame(8'h96, 2, 2, 1);
        check("irq_lag_at_stop_end", 32'(IRQ), 32'd0);
        @(negedge clk);
        check("irq_after_stop", 32'(IRQ), 32'd1);
        wr(A_DATA, 32'h3C);
        @(negedge clk);
        check("irq_drop_on_data", 32'(IRQ), 32'd0);
        wait_fall(5, "irq_frame2_start");
        check_frame(8'h3C, 2, 2, 1);
        @(negedge clk);
        check("irq_again", 32'(IRQ), 32'd1);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        check("irq_drop_on_ie_clear", 32'(IRQ), 32'd0);

        // DIV=0 behaves as DIV=1
        wr(A_DIV, 32'h0);
        wr(A_DATA, 32'h5A);
        wait_fall(5, "div0_start");
        check_frame(8'h5A, 1, 1, 1);
        rd(A_STAT, 32'h001, "div0_done");

        // DIV change mid-frame takes effect from the next bit
        wr(A_DIV, 32'h4);
        wr(A_DATA, 32'hF0);
        wait_fall(5, "divchg_start");
        wr(A_DIV, 32'h2);
        check_frame(8'hF0, 4, 2, 2);
        rd(A_STAT, 32'h001, "divchg_done");

        // Clearing TXEN mid-frame finishes the frame and keeps the rest
        wr(A_CTRL, 32'h0);
        wr(A_DATA, 32'h11);
        wr(A_DATA, 32'h22);
        wr(A_DATA, 32'h33);
        rd(A_STAT, 32'h030, "txen_queued3");
        wr(A_CTRL, 32'h1);
        wait_fall(5, "txen_start");
        wr(A_CTRL, 32'h0);
        check_frame(8'h11, 2, 2, 2);
        rd(A_STAT, 32'h020, "txen_count2");
        check_idle(30, "txen_no_more_frames");
        rd(A_STAT, 32'h020, "txen_count2_kept");

        // Reset during DATA bit 3 of 0x22
        wr(A_CTRL, 32'h1);
        wait_fall(5, "rst_mid_start");
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", 32'(txd), 32'd1);
        rd(A_STAT, 32'h001, "rst_mid_count0");
        reset = 1'b0;
        check_idle(40, "rst_mid_no_tx");
        rd(A_DIV, 32'd868, "rst_mid_div");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
